// File: rtl/rca_lsq.sv
// In-order load/store queue between the RCA load/store units and a simple memory port.
// Keeps one memory operation in flight and returns aligned, extended load data.
module rca_lsq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      fn3,
    input  logic            load,
    input  logic            store,
    input  logic            new_request,
    output logic            lsq_full,
    output logic [XLEN-1:0] load_data,
    output logic            load_complete,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            misalign_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state, state_nx;

    logic [XLEN-1:0] q_addr [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [2:0]      q_fn3  [DEPTH];
    logic            q_load [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop, issue, not_empty;

    logic [XLEN-1:0] h_addr, h_data;
    logic [2:0]      h_fn3;
    logic            h_load, h_mis;
    logic [1:0]      h_off;
    logic [3:0]      h_be;
    logic [XLEN-1:0] h_wdata;

    logic [1:0]      ld_off;
    logic [2:0]      ld_fn3;
    logic [XLEN-1:0] ld_shift, ld_ext;

    assign not_empty = (count != '0);
    assign lsq_full  = (count == FULL_CNT);
    assign push      = new_request && !lsq_full && (load ^ store);

    assign h_addr = q_addr[rd_ptr];
    assign h_data = q_data[rd_ptr];
    assign h_fn3  = q_fn3[rd_ptr];
    assign h_load = q_load[rd_ptr];
    assign h_off  = h_addr[1:0];

    // Head decode: alignment, lane enables and lane-replicated store data.
    always_comb begin
        h_mis   = 1'b0;
        h_be    = '0;
        h_wdata = h_data;
        case (h_fn3[1:0])
            2'b00: begin
                h_be    = 4'b0001 << h_off;
                h_wdata = {4{h_data[7:0]}};
            end
            2'b01: begin
                h_mis   = h_off[0];
                h_be    = 4'b0011 << h_off;
                h_wdata = {2{h_data[15:0]}};
            end
            2'b10: begin
                h_mis   = |h_off;
                h_be    = 4'b1111;
            end
            default: h_mis = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= addr;
            q_data[wr_ptr] <= data;
            q_fn3[wr_ptr]  <= fn3;
            q_load[wr_ptr] <= load;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (not_empty && !h_mis) state_nx = ISSUE;
            ISSUE:   if (mem_ack) state_nx = mem_we ? IDLE : WAIT;
            WAIT:    if (mem_rvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        misalign_err = 1'b0;
        issue        = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                misalign_err = not_empty && h_mis;
                issue        = not_empty && !h_mis;
                pop          = not_empty && h_mis;
            end
            ISSUE: begin
                mem_req = 1'b1;
                pop     = mem_ack;
            end
            default: ;
        endcase
    end

    assign ld_shift = mem_rdata >> {ld_off, 3'b000};

    always_comb begin
        case (ld_fn3[1:0])
            2'b00:   ld_ext = {{(XLEN-8){~ld_fn3[2] & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_ext = {{(XLEN-16){~ld_fn3[2] & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // The head is popped on mem_ack, so the load's lane/sign info is kept here for WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            ld_off        <= '0;
            ld_fn3        <= '0;
            load_data     <= '0;
            load_complete <= 1'b0;
        end else begin
            load_complete <= 1'b0;
            if (issue) begin
                mem_we    <= !h_load;
                mem_addr  <= {h_addr[XLEN-1:2], 2'b00};
                mem_be    <= h_be;
                mem_wdata <= h_wdata;
                ld_off    <= h_off;
                ld_fn3    <= h_fn3;
            end
            if (state == WAIT && mem_rvalid) begin
                load_data     <= ld_ext;
                load_complete <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rca_lsq.sv
// Directed bench for rca_lsq: transaction-level queue model checked every cycle,
// plus literal expectations for the hand-computed scenarios.
module tb_rca_lsq;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, data = '0;
    logic [2:0]  fn3 = '0;
    logic        load = 1'b0, store = 1'b0, new_request = 1'b0;
    logic        lsq_full, load_complete, mem_req, mem_we, misalign_err;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    rca_lsq #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .fn3(fn3),
        .load(load), .store(store), .new_request(new_request),
        .lsq_full(lsq_full), .load_data(load_data), .load_complete(load_complete),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        logic        ld;
    } req_t;

    req_t q[$];

    function automatic int sz(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit is_mis(input req_t r);
        if (r.f[1:0] == 2'b11) return 1'b1;
        return (int'(r.a[1:0]) % sz(r.f)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input req_t r);
        logic [3:0] b;
        int o = int'(r.a[1:0]);
        int s = sz(r.f);
        for (int i = 0; i < 4; i++) b[i] = (i >= o) && (i < o + s);
        return b;
    endfunction

    function automatic logic [31:0] exp_wd(input req_t r);
        logic [31:0] w;
        int s = sz(r.f);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = r.d[8*(i % s) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [2:0] f, input logic [1:0] o,
                                           input logic [31:0] rd);
        logic [31:0] v, mask;
        int s = sz(f);
        v    = rd >> (8 * int'(o));
        mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
        v    = v & mask;
        if (!f[2] && s < 4 && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    bit          wait_ld = 1'b0, lc_next = 1'b0;
    logic [2:0]  w_f = '0;
    logic [1:0]  w_o = '0;
    logic [31:0] ld_next = '0, last_ld = '0;

    always @(negedge clk) begin
        bit   full;
        req_t h;
        if (!rst) begin
            chk("rst_lsq_full", lsq_full, 0);
            chk("rst_load_complete", load_complete, 0);
            chk("rst_load_data", load_data, 0);
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_be", mem_be, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_misalign_err", misalign_err, 0);
            q.delete();
            wait_ld = 1'b0;
            lc_next = 1'b0;
            last_ld = '0;
        end else begin
            full = (q.size() == DEPTH);
            chk("lsq_full", lsq_full, full);
            if (lc_next) last_ld = ld_next;
            chk("load_complete", load_complete, lc_next);
            chk("load_data", load_data, last_ld);
            lc_next = 1'b0;
            if (mem_rvalid && wait_ld) begin
                lc_next = 1'b1;
                ld_next = exp_ld(w_f, w_o, mem_rdata);
                wait_ld = 1'b0;
            end
            if (misalign_err) begin
                chk("misalign_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    chk("misalign_head_bad", is_mis(q[0]), 1);
                    void'(q.pop_front());
                end
            end
            if (mem_req) begin
                chk("req_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    h = q[0];
                    chk("req_aligned", is_mis(h), 0);
                    chk("mem_we", mem_we, !h.ld);
                    chk("mem_addr", mem_addr, h.a - (h.a % 4));
                    chk("mem_be", mem_be, exp_be(h));
                    if (!h.ld) chk("mem_wdata", mem_wdata, exp_wd(h));
                    if (mem_ack) begin
                        void'(q.pop_front());
                        if (h.ld) begin
                            wait_ld = 1'b1;
                            w_f     = h.f;
                            w_o     = h.a[1:0];
                        end
                    end
                end
            end
            if (new_request && !full && (load ^ store))
                q.push_back('{a: addr, d: data, f: fn3, ld: load});
        end
    end

    // ---------------- memory responder ----------------
    bit          ack_en = 1'b0, rv_en = 1'b1;
    logic [31:0] rdata_val = '0;
    int          rd_pend = 0;

    always @(negedge clk)
        if (rst && mem_req && mem_ack && !mem_we) rd_pend++;

    always @(posedge clk) begin
        #1;
        mem_rvalid = 1'b0;
        if (rd_pend > 0 && rv_en) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata_val;
            rd_pend--;
        end
        mem_ack = ack_en && mem_req;
    end

    // ---------------- directed stimulus ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                        input logic ld, input logic st);
        addr = a; data = d; fn3 = f; load = ld; store = st; new_request = 1'b1;
        @(posedge clk);
        #1;
        new_request = 1'b0; load = 1'b0; store = 1'b0;
    endtask

    task automatic wait_ack(input string nm, input logic ew, input logic [31:0] ea,
                            input logic [3:0] eb, input logic [31:0] ewd);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (mem_req && mem_ack) got = 1'b1;
        end
        chk({nm, "_ack_seen"}, got, 1);
        if (got) begin
            chk({nm, "_we"}, mem_we, ew);
            chk({nm, "_addr"}, mem_addr, ea);
            chk({nm, "_be"}, mem_be, eb);
            if (ew) chk({nm, "_wdata"}, mem_wdata, ewd);
        end
    endtask

    task automatic wait_lc(input string nm, input logic [31:0] ed);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (load_complete) got = 1'b1;
        end
        chk({nm, "_complete_seen"}, got, 1);
        if (got) chk({nm, "_load_data"}, load_data, ed);
    endtask

    task automatic wait_mis(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (misalign_err) got = 1'b1;
        end
        chk({nm, "_misalign_seen"}, got, 1);
        if (got) chk({nm, "_no_req"}, mem_req, 0);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b1;
        ack_en = 1'b1;
        rv_en  = 1'b1;

        // LH 0x102: upper half 0x8001 sign-extends; mem_req two cycles after push
        rdata_val = 32'h8001_1234;
        push(32'h102, 32'h0, 3'b001, 1'b1, 1'b0);
        @(negedge clk); chk("t1_decode_no_req", mem_req, 0);
        @(negedge clk); chk("t1_req_at_n2", mem_req, 1);
        chk("t1_be", mem_be, 4'b1100);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_we", mem_we, 0);
        wait_lc("t1", 32'hFFFF_8001);
        sync();

        // LBU 0x203
        rdata_val = 32'hAB00_0000;
        push(32'h203, 32'h0, 3'b100, 1'b1, 1'b0);
        wait_ack("t2", 1'b0, 32'h200, 4'b1000, 32'h0);
        wait_lc("t2", 32'h0000_00AB);
        sync();

        // SH 0x10
        push(32'h10, 32'h0000_BEEF, 3'b001, 1'b0, 1'b1);
        wait_ack("t3", 1'b1, 32'h10, 4'b0011, 32'hBEEF_BEEF);
        repeat (4) begin @(negedge clk); chk("t3_no_complete", load_complete, 0); end
        sync();

        // load and store both set: dropped
        push(32'h30, 32'h0, 3'b010, 1'b1, 1'b1);
        repeat (4) begin @(negedge clk); chk("drop_no_req", mem_req, 0); end
        sync();

        // fill with memory stalled; fifth request must be ignored
        ack_en = 1'b0;
        push(32'h20, 32'h1111_1111, 3'b010, 1'b0, 1'b1);
        push(32'h21, 32'h0000_0022, 3'b000, 1'b0, 1'b1);
        push(32'h24, 32'h0, 3'b010, 1'b1, 1'b0);
        push(32'h26, 32'h0000_3344, 3'b001, 1'b0, 1'b1);
        @(negedge clk); chk("t4_full", lsq_full, 1);
        sync();
        push(32'h27, 32'h0, 3'b000, 1'b1, 1'b0);
        @(negedge clk); chk("t4_still_full", lsq_full, 1);
        sync();
        rdata_val = 32'h5566_7788;
        ack_en    = 1'b1;
        wait_ack("t4a", 1'b1, 32'h20, 4'b1111, 32'h1111_1111);
        @(negedge clk); chk("t4_full_drop", lsq_full, 0);
        wait_ack("t4b", 1'b1, 32'h20, 4'b0010, 32'h2222_2222);
        wait_ack("t4c", 1'b0, 32'h24, 4'b1111, 32'h0);
        wait_lc("t4c", 32'h5566_7788);
        wait_ack("t4d", 1'b1, 32'h24, 4'b1100, 32'h3344_3344);
        repeat (6) begin @(negedge clk); chk("t4_fifth_dropped", mem_req, 0); end
        sync();

        // misaligned requests are dropped with a pulse; the next one proceeds
        rdata_val = 32'hCAFE_F00D;
        push(32'h6, 32'h0, 3'b010, 1'b1, 1'b0);
        wait_mis("t5_lw6");
        sync();
        push(32'h8, 32'h0, 3'b010, 1'b1, 1'b0);
        wait_ack("t5_lw8", 1'b0, 32'h8, 4'b1111, 32'h0);
        wait_lc("t5_lw8", 32'hCAFE_F00D);
        sync();
        push(32'h0, 32'h0, 3'b011, 1'b1, 1'b0);
        wait_mis("t5_fn3_11");
        sync();
        push(32'h1, 32'h0, 3'b001, 1'b0, 1'b1);
        wait_mis("t5_sh1");
        sync();

        // reset while waiting for read data with two entries still queued
        ack_en = 1'b0;
        rv_en  = 1'b0;
        push(32'h40, 32'h0, 3'b010, 1'b1, 1'b0);
        push(32'h44, 32'h0, 3'b010, 1'b1, 1'b0);
        push(32'h48, 32'h0, 3'b010, 1'b1, 1'b0);
        ack_en = 1'b1;
        wait_ack("t6", 1'b0, 32'h40, 4'b1111, 32'h0);
        @(negedge clk); chk("t6_wait_no_req", mem_req, 0);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_load_data", load_data, 0);
        chk("t6_rst_mem_addr", mem_addr, 0);
        chk("t6_rst_mem_be", mem_be, 0);
        chk("t6_rst_mem_req", mem_req, 0);
        chk("t6_rst_full", lsq_full, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        rv_en = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("t6_no_late_complete", load_complete, 0);
            chk("t6_no_req", mem_req, 0);
        end
        sync();

        // queue usable after reset: LB 0x1 with negative byte
        rdata_val = 32'h0000_8000;
        push(32'h1, 32'h0, 3'b000, 1'b1, 1'b0);
        wait_ack("t7", 1'b0, 32'h0, 4'b0010, 32'h0);
        wait_lc("t7", 32'hFFFF_FF80);
        repeat (3) @(negedge clk);

        chk("drain_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
